mem_wb_hilo: RTL and testbench
==============================

Name: mem_wb_hilo

Overview:
- Receiving end of the MEM stage result interface.
- Registers the MEM-stage result into the WB stage under pipeline stall/flush control, drives the regfile write port, and owns the architectural HI/LO registers.
- Provides a bypassed HI/LO read port to EX so MFHI/MFLO see in-flight writes.
- Also keeps a free-running count of instructions captured into WB.

Parameters:
- DATA_W, 32, width of GPR data and of HI/LO.
- ADDR_W, 5, width of the GPR write address.
- CNT_W, 32, width of the WB capture counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled.
- flush  in  1  exception flush; clears the WB stage.
- mem_wd_i  in  ADDR_W  destination register from MEM.
- mem_wdata_i  in  DATA_W  write data from MEM.
- mem_wreg_i  in  1  GPR write enable from MEM.
- mem_hi_i  in  DATA_W  HI value from MEM.
- mem_lo_i  in  DATA_W  LO value from MEM.
- mem_whilo_i  in  1  HI/LO write enable from MEM.
- wb_wd_o  out  ADDR_W  regfile write address.
- wb_wdata_o  out  DATA_W  regfile write data.
- wb_wreg_o  out  1  regfile write enable.
- hi_o  out  DATA_W  architectural HI register.
- lo_o  out  DATA_W  architectural LO register.
- ex_hi_o  out  DATA_W  bypassed HI for EX.
- ex_lo_o  out  DATA_W  bypassed LO for EX.
- wb_cnt_o  out  CNT_W  number of MEM results captured into WB.

Behaviour:
- Reset (rst==0, asynchronous): all WB registers go to 0, including wd, wdata, wreg, hi, lo and whilo. HI, LO and wb_cnt_o also go to 0. All outputs are 0 while reset is held.
- WB register update, per rising edge, evaluated in priority order:
  1. flush==1: load a bubble (all WB fields 0).
  2. stall[4]==1 and stall[5]==0: load a bubble.
  3. stall[4]==0: capture all six MEM inputs.
  4. Otherwise (both stalled): hold.
- wb_cnt_o increments by 1 only in case 3. It wraps modulo 2^CNT_W. No increment on bubble, hold, or flush.
- Regfile outputs wb_wd_o, wb_wdata_o and wb_wreg_o are driven directly from the WB registers. Latency from MEM input to regfile port is 1 cycle.
- HI/LO commit: on a rising edge, if the WB register's whilo==1, HI<=WB hi and LO<=WB lo. Latency from MEM input to HI/LO is 2 edges.
  - Commit happens on the same edge regardless of flush or stall. The instruction already in WB has retired, so a flush only kills the incoming one.
  - If stall[5]==1 with both stalled, WB holds and recommits the same value. This is idempotent and allowed.
- Bypass, combinational, priority high to low:
  1. mem_whilo_i==1: ex_hi_o/ex_lo_o = mem_hi_i/mem_lo_i.
  2. WB whilo==1: WB hi/lo.
  3. Otherwise: HI/LO registers.
- HI and LO are always written together; there are no partial writes.
- Reset asserted mid-operation discards any pending WB commit. Deassertion takes effect at the next edge with normal behaviour.

Decomposition:
- Shared defines header carries the existing bus-width and constant macros: RegBus, RegAddrBus, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, and the stall bit indices.
- Add a new macro for the active-low reset-assert level.
- One natural sub-module: hilo_reg. It holds the HI/LO storage, commit logic and bypass mux.
- The WB pipeline register and counter stay in the top module.

Test Plan:
- Reset: hold rst=0 with random inputs, then release.
  - Required: all outputs 0 while held, including wb_cnt_o=0, and stay 0 until the first capture.
- Capture: stall=0, drive mem_wd_i=5'd3, mem_wdata_i=32'hDEADBEEF, mem_wreg_i=1.
  - Required: after 1 edge, wb_wd_o=3, wb_wdata_o=DEADBEEF, wb_wreg_o=1, wb_cnt_o=1.
- HI/LO path: drive mem_hi_i=32'h1, mem_lo_i=32'h2, mem_whilo_i=1 for one cycle, then whilo=0.
  - Required: ex_hi_o/ex_lo_o=1/2 immediately; hi_o/lo_o=1/2 after the 2nd edge; ex_* still 1/2 throughout.
- Stall bubble: set stall=6'b010000 with valid MEM inputs.
  - Required: WB becomes a bubble (wb_wreg_o=0), wb_cnt_o unchanged.
  - Then stall=6'b110000: WB holds the bubble.
- Flush with pending commit: WB holds whilo=1 with hi=32'hA, lo=32'hB; assert flush together with a new MEM whilo write.
  - Required: HI/LO=A/B after the edge, WB becomes a bubble, the new write never commits.
- Counter wrap: force the counter to 32'hFFFFFFFF, then perform 1 capture.
  - Required: wb_cnt_o=0.

Source files
------------

// File: rtl/mem_wb_hilo_pkg.sv
// Shared pipeline macros plus the WB-stage update decode used by mem_wb_hilo.
`ifndef MEM_WB_HILO_DEFINES
`define MEM_WB_HILO_DEFINES
`define RegBus        31:0
`define RegAddrBus    4:0
`define ZeroWord      32'h0000_0000
`define NOPRegAddr    5'b00000
`define WriteEnable   1'b1
`define WriteDisable  1'b0
`define StallMem      4
`define StallWb       5
`define RstEnable     1'b0
`endif

package mem_wb_hilo_pkg;

  localparam int unsigned StallW      = 6;
  localparam int unsigned StallMemBit = `StallMem;
  localparam int unsigned StallWbBit  = `StallWb;

  typedef enum logic [1:0] {
    WbHold    = 2'd0,
    WbBubble  = 2'd1,
    WbCapture = 2'd2
  } wb_act_e;

  // Flush beats everything; a stalled MEM feeding a running WB must insert a bubble.
  function automatic wb_act_e wb_action(input logic flush, input logic [StallW-1:0] stall);
    wb_act_e act;
    if (flush) begin
      act = WbBubble;
    end else if (stall[StallMemBit] && !stall[StallWbBit]) begin
      act = WbBubble;
    end else if (!stall[StallMemBit]) begin
      act = WbCapture;
    end else begin
      act = WbHold;
    end
    return act;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO storage with commit from WB and a bypass read port for EX.
module hilo_reg
  import mem_wb_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] ex_hi_o,
  output logic [DATA_W-1:0] ex_lo_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_we_i == `WriteEnable) begin
      hi_d = wb_hi_i;
      lo_d = wb_lo_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == `RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Youngest in-flight write wins; the bypass is forced to zero while reset is held.
  always_comb begin
    ex_hi_o = hi_q;
    ex_lo_o = lo_q;
    if (rst_ni == `RstEnable) begin
      ex_hi_o = '0;
      ex_lo_o = '0;
    end else if (mem_we_i == `WriteEnable) begin
      ex_hi_o = mem_hi_i;
      ex_lo_o = mem_lo_i;
    end else if (wb_we_i == `WriteEnable) begin
      ex_hi_o = wb_hi_i;
      ex_lo_o = wb_lo_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register driving the regfile write port, HI/LO ownership and a capture counter.
module mem_wb_hilo
  import mem_wb_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic              mem_whilo_i,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] ex_hi_o,
  output logic [DATA_W-1:0] ex_lo_o,
  output logic [CNT_W-1:0]  wb_cnt_o
);

  wb_act_e wb_act;

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              whilo_q, whilo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign wb_act = wb_action(flush, stall);

  always_comb begin
    wd_d    = wd_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    cnt_d   = cnt_q;
    unique case (wb_act)
      WbBubble: begin
        wd_d    = '0;
        wdata_d = '0;
        wreg_d  = `WriteDisable;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = `WriteDisable;
      end
      WbCapture: begin
        wd_d    = mem_wd_i;
        wdata_d = mem_wdata_i;
        wreg_d  = mem_wreg_i;
        hi_d    = mem_hi_i;
        lo_d    = mem_lo_i;
        whilo_d = mem_whilo_i;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      wd_q    <= '0;
      wdata_q <= '0;
      wreg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      cnt_q   <= cnt_d;
    end
  end

  // The instruction sitting in WB commits on this edge even when the incoming one is flushed.
  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo_reg (
    .clk_i   (clk),
    .rst_ni  (rst),
    .wb_we_i (whilo_q),
    .wb_hi_i (hi_q),
    .wb_lo_i (lo_q),
    .mem_we_i(mem_whilo_i),
    .mem_hi_i(mem_hi_i),
    .mem_lo_i(mem_lo_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .ex_hi_o (ex_hi_o),
    .ex_lo_o (ex_lo_o)
  );

  assign wb_wd_o    = wd_q;
  assign wb_wdata_o = wdata_q;
  assign wb_wreg_o  = wreg_q;
  assign wb_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Scoreboard bench for mem_wb_hilo: driver pushes model predictions, monitor pops and compares.
module tb_mem_wb_hilo;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        mem_wreg_i;
  logic [31:0] mem_hi_i;
  logic [31:0] mem_lo_i;
  logic        mem_whilo_i;

  logic [4:0]  wb_wd_o;
  logic [31:0] wb_wdata_o;
  logic        wb_wreg_o;
  logic [31:0] hi_o, lo_o, ex_hi_o, ex_lo_o, wb_cnt_o;

  logic [4:0]  s_wd_o;
  logic [31:0] s_wdata_o;
  logic        s_wreg_o;
  logic [31:0] s_hi_o, s_lo_o, s_ex_hi_o, s_ex_lo_o;
  logic [3:0]  s_cnt_o;

  mem_wb_hilo dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .mem_wreg_i(mem_wreg_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
    .wb_wd_o(wb_wd_o), .wb_wdata_o(wb_wdata_o), .wb_wreg_o(wb_wreg_o),
    .hi_o(hi_o), .lo_o(lo_o), .ex_hi_o(ex_hi_o), .ex_lo_o(ex_lo_o), .wb_cnt_o(wb_cnt_o)
  );

  // Narrow counter copy so modulo wrap is reached within a short run.
  mem_wb_hilo #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .mem_wreg_i(mem_wreg_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
    .wb_wd_o(s_wd_o), .wb_wdata_o(s_wdata_o), .wb_wreg_o(s_wreg_o),
    .hi_o(s_hi_o), .lo_o(s_lo_o), .ex_hi_o(s_ex_hi_o), .ex_lo_o(s_ex_lo_o), .wb_cnt_o(s_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] hi, lo, exhi, exlo, cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: the instruction currently held in WB plus architectural state.
  logic [4:0]  m_wd;
  logic [31:0] m_wdata, m_whi, m_wlo, m_hi, m_lo, m_cnt;
  logic        m_wreg, m_whilo;

  function automatic void model_reset();
    m_wd = '0; m_wdata = '0; m_wreg = 1'b0; m_whi = '0; m_wlo = '0; m_whilo = 1'b0;
    m_hi = '0; m_lo = '0; m_cnt = '0;
  endfunction

  // What the rising edge does, given the inputs present at that edge.
  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      if (m_whilo) begin
        m_hi = m_whi;
        m_lo = m_wlo;
      end
      if (flush || (stall[4] && !stall[5])) begin
        m_wd = '0; m_wdata = '0; m_wreg = 1'b0; m_whi = '0; m_wlo = '0; m_whilo = 1'b0;
      end else if (!stall[4]) begin
        m_wd = mem_wd_i; m_wdata = mem_wdata_i; m_wreg = mem_wreg_i;
        m_whi = mem_hi_i; m_wlo = mem_lo_i; m_whilo = mem_whilo_i;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.wd = m_wd; e.wdata = m_wdata; e.wreg = m_wreg;
    e.hi = m_hi; e.lo = m_lo; e.cnt = m_cnt; e.cnt4 = m_cnt[3:0];
    if (!rst) begin
      e.exhi = '0; e.exlo = '0;
    end else if (mem_whilo_i) begin
      e.exhi = mem_hi_i; e.exlo = mem_lo_i;
    end else if (m_whilo) begin
      e.exhi = m_whi; e.exlo = m_wlo;
    end else begin
      e.exhi = m_hi; e.exlo = m_lo;
    end
    return e;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] st, input logic fl, input logic [4:0] wd,
                     input logic [31:0] wdata, input logic wreg, input logic [31:0] hi,
                     input logic [31:0] lo, input logic whilo);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; stall = st; flush = fl;
    mem_wd_i = wd; mem_wdata_i = wdata; mem_wreg_i = wreg;
    mem_hi_i = hi; mem_lo_i = lo; mem_whilo_i = whilo;
    if (!r) model_reset();
    sb.push_back(predict());
  endtask

  task automatic rcyc(input logic r, input logic [5:0] st, input logic fl);
    cyc(r, st, fl, 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom));
  endtask

  function automatic logic [5:0] rand_stall();
    logic [5:0] s;
    s = 6'($urandom);
    s[4] = ($urandom_range(0, 9) < 3);
    s[5] = s[4] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_wd",    32'(wb_wd_o),    32'(e.wd));
        chk("wb_wdata", wb_wdata_o,      e.wdata);
        chk("wb_wreg",  32'(wb_wreg_o),  32'(e.wreg));
        chk("hi",       hi_o,            e.hi);
        chk("lo",       lo_o,            e.lo);
        chk("ex_hi",    ex_hi_o,         e.exhi);
        chk("ex_lo",    ex_lo_o,         e.exlo);
        chk("wb_cnt",   wb_cnt_o,        e.cnt);
        chk("cnt_wrap", 32'(s_cnt_o),    32'(e.cnt4));
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    rst = 1'b0; stall = '0; flush = 1'b0;
    mem_wd_i = '0; mem_wdata_i = '0; mem_wreg_i = 1'b0;
    mem_hi_i = '0; mem_lo_i = '0; mem_whilo_i = 1'b0;
    model_reset();

    // Reset held with random inputs: everything must read zero.
    for (int i = 0; i < 4; i++) rcyc(1'b0, 6'($urandom), 1'($urandom));
    cyc(1'b1, 6'b110000, 1'b0, 5'd9, 32'h1234, 1'b1, 32'h5, 32'h6, 1'b0);

    // Capture.
    cyc(1'b1, 6'b000000, 1'b0, 5'd3, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b0);
    // HI/LO path: write pulse then idle.
    cyc(1'b1, 6'b000000, 1'b0, 5'd4, 32'h11, 1'b1, 32'h1, 32'h2, 1'b1);
    cyc(1'b1, 6'b000000, 1'b0, 5'd5, 32'h22, 1'b0, 32'h77, 32'h88, 1'b0);
    cyc(1'b1, 6'b000000, 1'b0, 5'd6, 32'h33, 1'b0, 32'h99, 32'haa, 1'b0);
    cyc(1'b1, 6'b000000, 1'b0, 5'd7, 32'h44, 1'b1, 32'h0, 32'h0, 1'b0);
    // Stall bubble, then both stalled holding the bubble.
    cyc(1'b1, 6'b010000, 1'b0, 5'd8, 32'h55, 1'b1, 32'h3, 32'h4, 1'b1);
    cyc(1'b1, 6'b110000, 1'b0, 5'd8, 32'h55, 1'b1, 32'h3, 32'h4, 1'b0);
    cyc(1'b1, 6'b110000, 1'b0, 5'd8, 32'h55, 1'b1, 32'h3, 32'h4, 1'b0);
    // Flush with a pending commit of A/B in WB; the incoming C/D must never land.
    cyc(1'b1, 6'b000000, 1'b0, 5'd10, 32'h66, 1'b1, 32'hA, 32'hB, 1'b1);
    cyc(1'b1, 6'b000000, 1'b1, 5'd11, 32'h77, 1'b1, 32'hC, 32'hD, 1'b1);
    cyc(1'b1, 6'b000000, 1'b0, 5'd12, 32'h88, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 6'b000000, 1'b0, 5'd13, 32'h99, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic including mid-operation resets.
    for (int i = 0; i < 400; i++) begin
      rcyc(($urandom_range(0, 59) != 0), rand_stall(), ($urandom_range(0, 9) == 0));
    end

    // Plain captures to push both counters well past the narrow wrap point.
    for (int i = 0; i < 20; i++) rcyc(1'b1, 6'b000000, 1'b0);

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
